// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath blocks.
//   FFT_WIDTH   : default data word width (packed re/im)
//   fft_dw()    : width of a delay/count port for a given maximum depth
//   clamp_delay : maps a requested delay into the legal range 1..max_depth;
//                 also used by the FFT stage controller
package fft_pkg;

  localparam int FFT_WIDTH = 32;

  // Enough bits to hold the value max_depth itself.
  function automatic int fft_dw(input int max_depth);
    return $clog2(max_depth) + 1;
  endfunction

  // A delay of 0 is meaningless for a sample-counted line, so it becomes 1.
  function automatic int unsigned clamp_delay(input int unsigned d,
                                              input int unsigned max_depth);
    if (d == 0)
      return 1;
    else if (d > max_depth)
      return max_depth;
    else
      return d;
  endfunction

endpackage

// File: rtl/vdl_sdp_ram.sv
// Simple dual-port RAM for var_delay_line.
//   clk, rst : clock and async active-high reset (read register only)
//   we, waddr, wdata : write port
//   re, raddr, rdata : synchronous read port; rdata holds when re is low
// On an address collision the read returns the old contents. Memory contents
// are never reset.
module vdl_sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  // Non-blocking write above means a same-edge read sees the previous word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata <= '0;
    else if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/var_delay_line.sv
// Runtime-programmable, sample-counted delay line (RAM circular buffer).
// Optional macro: VAR_DELAY_LINE_PIPE_OUT_EN adds a register stage after the
// RAM read; out_valid/out_data then appear one clock after the accept edge.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   in_valid     : accept in_data this cycle
//   in_data      : input sample
//   delay_load   : strobe; latch clamp(delay_in, 1, MAX_DEPTH), restart history
//   delay_in     : requested delay in samples
//   flush        : restart history, keep delay
//   out_valid    : out_data was updated with a delayed sample
//   out_data     : delayed sample
//   fill_level   : accepted samples since flush/load/reset, saturating
module var_delay_line
  import fft_pkg::*;
#(
  parameter int   WIDTH     = FFT_WIDTH,
  parameter int   MAX_DEPTH = 512,
  parameter int   RST_DELAY = 512,
  localparam int  DW        = fft_dw(MAX_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             delay_load,
  input  logic [DW-1:0]    delay_in,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [DW-1:0]    fill_level
);

  localparam int AW = $clog2(MAX_DEPTH);
  localparam logic [DW-1:0] MAX_FILL = DW'(MAX_DEPTH);

  logic [AW-1:0]    wp;
  logic [DW-1:0]    delay_reg;
  logic             restart;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;

  // A load or flush starts a new history; a coincident sample is its first.
  assign restart = delay_load | flush;
  assign rd_en   = in_valid & ~restart & (fill_level >= delay_reg);
  // MAX_DEPTH is a power of two, so dropping the top bit is the modulo.
  assign rd_addr = wp - delay_reg[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp         <= '0;
      fill_level <= '0;
      delay_reg  <= DW'(RST_DELAY);
      vld_p0     <= 1'b0;
    end else begin
      if (in_valid)
        wp <= wp + 1'b1;
      if (delay_load)
        delay_reg <= DW'(clamp_delay(32'(delay_in), MAX_DEPTH));
      if (restart)
        fill_level <= {{(DW-1){1'b0}}, in_valid};
      else if (in_valid && fill_level != MAX_FILL)
        fill_level <= fill_level + 1'b1;
      vld_p0 <= rd_en;
    end
  end

  vdl_sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (in_valid),
    .waddr (wp),
    .wdata (in_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (data_p0)
  );

`ifdef VAR_DELAY_LINE_PIPE_OUT_EN
  // ---- stage p0 -> p1: RAM output retimed into fabric ----
  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      data_p1 <= data_p0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
`else
  assign out_valid = vld_p0;
  assign out_data  = data_p0;
`endif

endmodule

// File: tb/tb_var_delay_line.sv
// Self-checking bench for var_delay_line (MAX_DEPTH=8, RST_DELAY=4).
module tb_var_delay_line;

  localparam int WIDTH = 32;
  localparam int MAXD  = 8;
  localparam int RSTD  = 4;
  localparam int DW    = $clog2(MAXD) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             delay_load = 1'b0;
  logic [DW-1:0]    delay_in = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [DW-1:0]    fill_level;

  int checks = 0;
  int errors = 0;

  // Reference model: the history since the last restart as a queue of samples.
  int unsigned hist[$];
  int          delay_m;
  logic        exp_v;
  logic [31:0] exp_d;
  logic        exp_pv;
  logic [31:0] exp_pd;

  var_delay_line #(
    .WIDTH     (WIDTH),
    .MAX_DEPTH (MAXD),
    .RST_DELAY (RSTD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .delay_load (delay_load),
    .delay_in   (delay_in),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    delay_m = RSTD;
    exp_v = 1'b0; exp_d = '0; exp_pv = 1'b0; exp_pd = '0;
  endtask

  function automatic int exp_fill();
    return (hist.size() > MAXD) ? MAXD : hist.size();
  endfunction

  task automatic check_outputs(input string tag);
`ifdef VAR_DELAY_LINE_PIPE_OUT_EN
    check({tag, ".vld"}, 64'(out_valid), 64'(exp_pv));
    check({tag, ".data"}, 64'(out_data), 64'(exp_pd));
`else
    check({tag, ".vld"}, 64'(out_valid), 64'(exp_v));
    check({tag, ".data"}, 64'(out_data), 64'(exp_d));
`endif
    check({tag, ".fill"}, 64'(fill_level), 64'(exp_fill()));
  endtask

  // One clock: drive inputs, advance the model across the edge, check after it.
  task automatic step(input string tag, input bit iv, input int unsigned d,
                      input bit ld, input int unsigned din, input bit fl);
    in_valid = iv; in_data = d; delay_load = ld; delay_in = DW'(din); flush = fl;
    @(posedge clk);
    exp_pv = exp_v;
    exp_pd = exp_d;
    if (ld)
      delay_m = (din == 0) ? 1 : (din > MAXD) ? MAXD : int'(din);
    if (ld || fl) begin
      hist.delete();
      if (iv) hist.push_back(d);
      exp_v = 1'b0;
    end else if (iv) begin
      if (hist.size() >= delay_m) begin
        exp_v = 1'b1;
        exp_d = hist[hist.size() - delay_m];
      end else begin
        exp_v = 1'b0;
      end
      hist.push_back(d);
      if (hist.size() > 4 * MAXD) void'(hist.pop_front());
    end else begin
      exp_v = 1'b0;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.vld", 64'(out_valid), 64'd0);
    check("rst.data", 64'(out_data), 64'd0);
    check("rst.fill", 64'(fill_level), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Default delay 4, values 1..20
    for (int i = 1; i <= 20; i++) step("seq20", 1'b1, i, 1'b0, 0, 1'b0);
    idle("seq20.idle");
    check("seq20.last", 64'(out_data), 64'd16);
    check("seq20.sat", 64'(fill_level), 64'd8);

    // Delay 3, gapped input
    step("ld3", 1'b0, 0, 1'b1, 3, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step("gap.acc", 1'b1, i, 1'b0, 0, 1'b0);
      idle("gap.idle1");
      idle("gap.idle2");
    end
    check("gap.last", 64'(out_data), 64'd7);

    // Delay = MAX_DEPTH: read/write address collision
    step("ld8", 1'b0, 0, 1'b1, 8, 1'b0);
    for (int i = 0; i < 24; i++) step("full", 1'b1, 100 + i, 1'b0, 0, 1'b0);
    idle("full.idle");
    check("full.last", 64'(out_data), 64'd115);

    // Reload with coincident sample
    step("ld4", 1'b0, 0, 1'b1, 4, 1'b0);
    for (int i = 0; i < 10; i++) step("pre", 1'b1, 200 + i, 1'b0, 0, 1'b0);
    step("ld2.s50", 1'b1, 50, 1'b1, 2, 1'b0);
    step("s51", 1'b1, 51, 1'b0, 0, 1'b0);
    step("s52", 1'b1, 52, 1'b0, 0, 1'b0);
    idle("s52.idle");
    check("s52.out", 64'(out_data), 64'd50);

    // Clamp limits and flush
    step("ld0", 1'b0, 0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 5; i++) step("d1", 1'b1, 300 + i, 1'b0, 0, 1'b0);
    step("ld13", 1'b0, 0, 1'b1, MAXD + 5, 1'b0);
    for (int i = 0; i < 12; i++) step("d8", 1'b1, 400 + i, 1'b0, 0, 1'b0);
    step("flush", 1'b0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 12; i++) step("postfl", 1'b1, 500 + i, 1'b0, 0, 1'b0);
    step("flld", 1'b1, 77, 1'b1, 3, 1'b1);
    for (int i = 0; i < 6; i++) step("flld.acc", 1'b1, 600 + i, 1'b0, 0, 1'b0);

    // Asynchronous reset between edges, mid-stream
    #2 rst = 1'b1;
    #1;
    check("arst.vld", 64'(out_valid), 64'd0);
    check("arst.data", 64'(out_data), 64'd0);
    check("arst.fill", 64'(fill_level), 64'd0);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 7; i++) step("arst.acc", 1'b1, 700 + i, 1'b0, 0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit iv, ld, fl;
      iv = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 29) == 0);
      fl = ($urandom_range(0, 29) == 0);
      step("rand", iv, $urandom, ld, $urandom_range(0, 15), fl);
    end
    idle("end.idle");
    idle("end.idle2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
